// File: rtl/bk_pkg.sv
// Shared Brent-Kung definitions: prefix depth, (G,P) pair type and legal width range.
package bk_pkg;
   localparam int MIN_WIDTH = 4;
   localparam int MAX_WIDTH = 64;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   function automatic int levels(input int width);
      return $clog2(width);
   endfunction
endpackage

// File: rtl/bk_prefix_cell.sv
// Brent-Kung (G,P) combine: high group absorbs the adjacent lower group.
module bk_prefix_cell (
   input  logic i_gh,
   input  logic i_ph,
   input  logic i_gl,
   input  logic i_pl,
   output logic o_g,
   output logic o_p
);
   assign o_g = i_gh | (i_ph & i_gl);
   assign o_p = i_ph & i_pl;
endmodule

// File: rtl/brent_kung_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready flow control.
// Stage 1: bitwise g/p, stage 2: up-sweep, stage 3: down-sweep and sum (optionally registered).
module brent_kung_adder_pipe
   import bk_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int REG_OUT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int LV = levels(WIDTH);

   if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("brent_kung_adder_pipe: WIDTH must be a power of two between 4 and 64");
   end

   logic                   w_adv;
   logic                   r_v1;
   logic                   r_v2;
   logic [WIDTH-1:0]       w_b_eff;
   logic [WIDTH-1:0]       r_g1;
   logic [WIDTH-1:0]       r_p1;
   logic                   r_c1;
   gp_t  [WIDTH-1:0]       w_up [0:LV];
   gp_t  [WIDTH-1:0]       r_gp2;
   logic [WIDTH-1:0]       r_p2;
   logic                   r_c2;
   gp_t  [WIDTH-1:0]       w_dn [0:LV-1];
   logic [WIDTH:0]         w_c;
   logic [WIDTH-1:0]       w_sum;
   logic                   w_cout;
   logic                   w_ovf;
   logic                   w_zero;

   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;
   assign w_b_eff  = sub ? ~b : b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
      end else if (w_adv) begin
         r_v1 <= in_valid;
         r_v2 <= r_v1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_adv) begin
         r_g1  <= a & w_b_eff;
         r_p1  <= a ^ w_b_eff;
         r_c1  <= sub | cin;
         r_gp2 <= w_up[LV];
         r_p2  <= r_p1;
         r_c2  <= r_c1;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_lvl0
      assign w_up[0][i] = {r_g1[i], r_p1[i]};
   end

   for (genvar l = 1; l <= LV; l++) begin : g_up
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if ((i + 1) % (1 << l) == 0) begin : g_cell
            logic w_g, w_p;
            bk_prefix_cell u_cell (
               .i_gh (w_up[l-1][i].g),
               .i_ph (w_up[l-1][i].p),
               .i_gl (w_up[l-1][i-(1 << (l-1))].g),
               .i_pl (w_up[l-1][i-(1 << (l-1))].p),
               .o_g  (w_g),
               .o_p  (w_p)
            );
            assign w_up[l][i] = {w_g, w_p};
         end else begin : g_pass
            assign w_up[l][i] = w_up[l-1][i];
         end
      end
   end

   // Down-sweep fills the gaps between the power-of-two prefixes left by the up-sweep.
   assign w_dn[LV-1] = r_gp2;

   for (genvar l = LV - 1; l >= 1; l--) begin : g_dn
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (((i + 1) % (1 << l)) == (1 << (l-1)) && (i + 1) > (1 << l)) begin : g_cell
            logic w_g, w_p;
            bk_prefix_cell u_cell (
               .i_gh (w_dn[l][i].g),
               .i_ph (w_dn[l][i].p),
               .i_gl (w_dn[l][i-(1 << (l-1))].g),
               .i_pl (w_dn[l][i-(1 << (l-1))].p),
               .o_g  (w_g),
               .o_p  (w_p)
            );
            assign w_dn[l-1][i] = {w_g, w_p};
         end else begin : g_pass
            assign w_dn[l-1][i] = w_dn[l][i];
         end
      end
   end

   assign w_c[0] = r_c2;
   for (genvar i = 0; i < WIDTH; i++) begin : g_carry
      assign w_c[i+1] = w_dn[0][i].g | (w_dn[0][i].p & r_c2);
   end

   assign w_sum  = r_p2 ^ w_c[WIDTH-1:0];
   assign w_cout = w_c[WIDTH];
   assign w_ovf  = w_c[WIDTH] ^ w_c[WIDTH-1];
   assign w_zero = ~|w_sum;

   if (REG_OUT != 0) begin : g_reg_out
      logic             r_v3;
      logic [WIDTH-1:0] r_sum;
      logic             r_cout;
      logic             r_ovf;
      logic             r_zero;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_v3   <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
         end else if (w_adv) begin
            r_v3 <= r_v2;
            if (r_v2) begin
               r_sum  <= w_sum;
               r_cout <= w_cout;
               r_ovf  <= w_ovf;
               r_zero <= w_zero;
            end
         end
      end

      assign out_valid = r_v3;
      assign sum       = r_sum;
      assign cout      = r_cout;
      assign ovf       = r_ovf;
      assign zero      = r_zero;
   end else begin : g_comb_out
      // Gate with valid so the outputs read zero while reset holds the stage empty.
      assign out_valid = r_v2;
      assign sum       = w_sum & {WIDTH{r_v2}};
      assign cout      = w_cout & r_v2;
      assign ovf       = w_ovf & r_v2;
      assign zero      = w_zero & r_v2;
   end
endmodule

// File: tb/tb_brent_kung_adder_pipe.sv
// Bench for brent_kung_adder_pipe: an 8-bit registered-output instance and a 16-bit combinational-output instance.
module tb_brent_kung_adder_pipe;
   localparam int W0 = 8;
   localparam int W1 = 16;

   typedef struct packed {
      logic [63:0] s;
      logic        co;
      logic        ov;
      logic        z;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [1:0]      in_valid_s;
   logic [1:0]      out_ready_s;
   logic [1:0]      cin_s;
   logic [1:0]      sub_s;
   logic [1:0]      in_ready_s;
   logic [1:0]      out_valid_s;
   logic [1:0]      cout_s;
   logic [1:0]      ovf_s;
   logic [1:0]      zero_s;
   logic [W0-1:0]   a0, b0, sum0;
   logic [W1-1:0]   a1, b1, sum1;
   logic [63:0]     sum_s [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign sum_s[0] = {{(64-W0){1'b0}}, sum0};
   assign sum_s[1] = {{(64-W1){1'b0}}, sum1};

   brent_kung_adder_pipe #(.WIDTH(W0), .REG_OUT(1)) u_dut0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
      .a(a0), .b(b0), .cin(cin_s[0]), .sub(sub_s[0]),
      .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
      .sum(sum0), .cout(cout_s[0]), .ovf(ovf_s[0]), .zero(zero_s[0])
   );

   brent_kung_adder_pipe #(.WIDTH(W1), .REG_OUT(0)) u_dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
      .a(a1), .b(b1), .cin(cin_s[1]), .sub(sub_s[1]),
      .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
      .sum(sum1), .cout(cout_s[1]), .ovf(ovf_s[1]), .zero(zero_s[1])
   );

   function automatic int lane_w(input int k);
      return (k == 0) ? W0 : W1;
   endfunction

   function automatic int lane_lat(input int k);
      return (k == 0) ? 3 : 2;
   endfunction

   function automatic logic [63:0] lane_mask(input int k);
      return (64'd1 << lane_w(k)) - 64'd1;
   endfunction

   // Reference: plain integer arithmetic on the operands, signed overflow from operand/result signs.
   function automatic exp_t model(input int w, input logic [63:0] va, input logic [63:0] vb,
                                  input logic vc, input logic vs);
      logic [63:0] m, bb;
      logic [64:0] full;
      exp_t        e;
      m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      bb   = vs ? (~vb & m) : (vb & m);
      full = {1'b0, va & m} + {1'b0, bb} + (vs ? 65'd1 : {64'd0, vc});
      e.s  = full[63:0] & m;
      e.co = full[w];
      e.ov = (va[w-1] == bb[w-1]) && (e.s[w-1] != va[w-1]);
      e.z  = (e.s == 64'd0);
      return e;
   endfunction

   function automatic logic [63:0] pick(input logic [63:0] m);
      case ($urandom_range(0, 7))
         0:       return m;
         1:       return 64'd0;
         default: return {$urandom, $urandom} & m;
      endcase
   endfunction

   function automatic exp_t observe(input int k);
      return {sum_s[k], cout_s[k], ovf_s[k], zero_s[k]};
   endfunction

   task automatic set_ops(input int k, input logic [63:0] va, input logic [63:0] vb,
                          input logic vc, input logic vs, input logic en);
      if (k == 0) begin
         a0 = va[W0-1:0];
         b0 = vb[W0-1:0];
      end else begin
         a1 = va[W1-1:0];
         b1 = vb[W1-1:0];
      end
      cin_s[k]      = vc;
      sub_s[k]      = vs;
      in_valid_s[k] = en;
   endtask

   task automatic drive_beat(input int k, input logic en, output exp_t e);
      logic [63:0] m, va, vb;
      logic        vc, vs;
      m  = lane_mask(k);
      va = pick(m);
      vb = pick(m);
      vc = 1'($urandom);
      vs = 1'($urandom);
      set_ops(k, va, vb, vc, vs, en);
      e = model(lane_w(k), va, vb, vc, vs);
   endtask

   task automatic test_reset();
      in_valid_s  = 2'b00;
      out_ready_s = 2'b11;
      cin_s       = 2'b00;
      sub_s       = 2'b00;
      set_ops(0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
      set_ops(1, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
      #1 rst = 1'b1;
      #2;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({out_valid_s[k], in_ready_s[k]} !== 2'b01) begin
            errors++;
            $display("FAIL reset_handshake lane%0d: out_valid=%b in_ready=%b, required 0 1",
                     k, out_valid_s[k], in_ready_s[k]);
         end
         checks++;
         if (observe(k) !== '0) begin
            errors++;
            $display("FAIL reset_outputs lane%0d: got %h, required all zero", k, observe(k));
         end
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_vectors();
      int   vk [5];
      exp_t ve [5];
      logic [63:0] va [5], vb [5];
      logic vc [5], vs [5];
      int   lat;
      logic seen;
      vk[0] = 0; va[0] = 64'h0D;   vb[0] = 64'hB0;   vc[0] = 0; vs[0] = 0; ve[0] = {64'hBD,   1'b0, 1'b0, 1'b0};
      vk[1] = 0; va[1] = 64'hFF;   vb[1] = 64'hFF;   vc[1] = 1; vs[1] = 0; ve[1] = {64'hFF,   1'b1, 1'b0, 1'b0};
      vk[2] = 0; va[2] = 64'h7A;   vb[2] = 64'h06;   vc[2] = 0; vs[2] = 1; ve[2] = {64'h74,   1'b1, 1'b0, 1'b0};
      vk[3] = 1; va[3] = 64'h7FFF; vb[3] = 64'h0001; vc[3] = 0; vs[3] = 0; ve[3] = {64'h8000, 1'b0, 1'b1, 1'b0};
      vk[4] = 1; va[4] = 64'h1234; vb[4] = 64'h1234; vc[4] = 0; vs[4] = 1; ve[4] = {64'h0000, 1'b1, 1'b0, 1'b1};
      for (int n = 0; n < 5; n++) begin
         @(posedge clk);
         #1;
         out_ready_s[vk[n]] = 1'b1;
         set_ops(vk[n], va[n], vb[n], vc[n], vs[n], 1'b1);
         lat  = 0;
         seen = 1'b0;
         while (!seen && lat < 10) begin
            @(posedge clk);
            lat++;
            #1 in_valid_s[vk[n]] = 1'b0;
            @(negedge clk);
            seen = out_valid_s[vk[n]];
         end
         checks++;
         if (lat != lane_lat(vk[n])) begin
            errors++;
            $display("FAIL vector%0d_latency: got %0d cycles, required %0d", n, lat, lane_lat(vk[n]));
         end
         checks++;
         if (observe(vk[n]) !== ve[n]) begin
            errors++;
            $display("FAIL vector%0d_result: got %h, required %h", n, observe(vk[n]), ve[n]);
         end
      end
      repeat (4) @(posedge clk);
   endtask

   // vmode 0: in_valid held high; 1: random. rmode 0: ready high; 1: 1,0,0 pattern; 2: random.
   task automatic test_stream(input int k, input int n, input int vmode, input int rmode, input string tag);
      exp_t q [$];
      exp_t pend, got, hv, e;
      int   sent = 0;
      int   cyc  = 0;
      logic held = 1'b0;
      @(posedge clk);
      #1;
      out_ready_s[k] = 1'b1;
      drive_beat(k, 1'b1, pend);
      while ((sent < n || q.size() > 0) && cyc < n * 4 + 50) begin
         @(negedge clk);
         got = observe(k);
         if (held) begin
            checks++;
            if (out_valid_s[k] !== 1'b1 || got !== hv) begin
               errors++;
               $display("FAIL %s_stall_hold lane%0d: got valid=%b %h, required valid=1 %h",
                        tag, k, out_valid_s[k], got, hv);
            end
         end
         held = out_valid_s[k] && !out_ready_s[k];
         hv   = got;
         if (out_valid_s[k] && out_ready_s[k]) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL %s_extra lane%0d: got %h, required no result", tag, k, got);
            end else begin
               e = q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL %s_result lane%0d: got %h, required %h", tag, k, got, e);
               end
            end
         end
         if (in_valid_s[k] && in_ready_s[k]) begin
            q.push_back(pend);
            sent++;
         end
         @(posedge clk);
         cyc++;
         #1;
         case (rmode)
            0:       out_ready_s[k] = 1'b1;
            1:       out_ready_s[k] = (cyc % 3 == 0);
            default: out_ready_s[k] = 1'($urandom);
         endcase
         if (sent < n)
            drive_beat(k, (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0), pend);
         else
            in_valid_s[k] = 1'b0;
      end
      checks++;
      if (sent < n || q.size() > 0) begin
         errors++;
         $display("FAIL %s_drain lane%0d: sent %0d of %0d, %0d results outstanding, required all delivered",
                  tag, k, sent, n, q.size());
      end
      if (vmode == 0 && rmode == 0) begin
         checks++;
         if (cyc != n + lane_lat(k)) begin
            errors++;
            $display("FAIL %s_throughput lane%0d: got %0d cycles, required %0d", tag, k, cyc, n + lane_lat(k));
         end
      end
      out_ready_s[k] = 1'b1;
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 2; k++) test_stream(k, 40, 0, 0, "back_to_back");
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < 2; k++) test_stream(k, 10, 0, 1, "backpressure");
   endtask

   task automatic test_random();
      for (int k = 0; k < 2; k++) test_stream(k, 1500, 1, 2, "random");
   endtask

   task automatic test_reset_midstream(input int k);
      exp_t e;
      int   lat;
      logic seen;
      @(posedge clk);
      #1;
      out_ready_s[k] = 1'b0;
      drive_beat(k, 1'b1, e);
      repeat (3) begin
         @(posedge clk);
         #1 drive_beat(k, 1'b1, e);
      end
      in_valid_s[k] = 1'b0;
      checks++;
      if (out_valid_s[k] !== 1'b1) begin
         errors++;
         $display("FAIL midreset_preload lane%0d: out_valid=%b, required 1", k, out_valid_s[k]);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (out_valid_s[k] !== 1'b0 || in_ready_s[k] !== 1'b1 || observe(k) !== '0) begin
         errors++;
         $display("FAIL midreset_clear lane%0d: out_valid=%b in_ready=%b outputs=%h, required 0 1 zero",
                  k, out_valid_s[k], in_ready_s[k], observe(k));
      end
      #1 rst = 1'b0;
      out_ready_s[k] = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid_s[k] !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL midreset_stale lane%0d: out_valid rose after release, required none", k);
      end
      @(posedge clk);
      #1 drive_beat(k, 1'b1, e);
      @(negedge clk);
      checks++;
      if (in_ready_s[k] !== 1'b1) begin
         errors++;
         $display("FAIL midreset_first_ready lane%0d: in_ready=%b, required 1", k, in_ready_s[k]);
      end
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 10) begin
         @(posedge clk);
         lat++;
         #1 in_valid_s[k] = 1'b0;
         @(negedge clk);
         seen = out_valid_s[k];
      end
      checks++;
      if (lat != lane_lat(k) || observe(k) !== e) begin
         errors++;
         $display("FAIL midreset_first_beat lane%0d: got %0d cycles %h, required %0d cycles %h",
                  k, lat, observe(k), lane_lat(k), e);
      end
      repeat (4) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_midstream(0);
      test_reset_midstream(1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
